disp_fetch_ctrl: RTL

Frame-buffer fetch sequencer for the display circuit. It runs in the ACLK domain and issues AXI4 read-address bursts that walk the frame buffer for the selected resolution. Each frame starts at a synchronised frame-start pulse. Requests are throttled against free space in the pixel FIFO, so the FIFO can never overflow. Each 64-bit beat carries two pixels ({8'h00,R,G,B} per 32-bit half, pixel 0 in bits 31:0); this block generates addresses only and does not touch data.

---
 rtl/disp_fetch_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/disp_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : disp_fetch_ctrl
//  Purpose  : Frame-buffer fetch sequencer. Walks the frame buffer of the
//             selected resolution with 16-beat AXI4 read-address bursts,
//             starting on each frame-start pulse and throttled against free
//             pixel-FIFO space and a limit on outstanding bursts. It generates
//             addresses only; read data goes straight into the pixel FIFO.
//  Ports    : ACLK/ARESETN      clock, asynchronous active-low reset
//             DISPON            display enable
//             DISPADDR          frame base byte address (bits 6:0 ignored)
//             RESOL             00 VGA, 01 XGA, 10 SXGA, 11 VGA
//             VSTART            synchronised frame-start pulse
//             FIFO_FREE         free pixel-FIFO entries (64-bit)
//             RBEAT             one read beat written into the FIFO
//             ARADDR..ARREADY   AXI4 read-address channel
//             FRAME_REQ_DONE    pulse after the last burst of a frame
//             FETCH_LATE        pulse when a frame start cuts a frame short
//  Revision : 1.0  initial release
// ============================================================================
module disp_fetch_ctrl #(
    parameter int C_FIFO_DEPTH      = 512,
    parameter int C_MAX_OUTSTANDING = 4
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic                          DISPON,
    input  logic [31:0]                   DISPADDR,
    input  logic [1:0]                    RESOL,
    input  logic                          VSTART,
    input  logic [$clog2(C_FIFO_DEPTH):0] FIFO_FREE,
    input  logic                          RBEAT,
    output logic [31:0]                   ARADDR,
    output logic [7:0]                    ARLEN,
    output logic [2:0]                    ARSIZE,
    output logic [1:0]                    ARBURST,
    output logic                          ARVALID,
    input  logic                          ARREADY,
    output logic                          FRAME_REQ_DONE,
    output logic                          FETCH_LATE
);

    // Frame lengths in 128-byte bursts
    localparam logic [15:0] LEN_VGA  = 16'd9600;
    localparam logic [15:0] LEN_XGA  = 16'd24576;
    localparam logic [15:0] LEN_SXGA = 16'd40960;
    localparam logic [3:0]  MAX_OUT  = 4'(C_MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_CHECK = 2'd2,
        S_ADDR  = 2'd3
    } state_t;

    state_t      state;
    logic [24:0] base;
    logic [1:0]  resol;
    logic [15:0] burst_idx;
    logic        pending;
    logic [15:0] obeats;
    logic [3:0]  obursts;
    logic [3:0]  beat_cnt;

    logic [15:0] frame_len;
    logic        last_burst;
    logic        handshake;
    logic        beat_wrap;
    logic        credit;
    logic        restart;
    logic [16:0] need;
    logic [16:0] free_ext;
    logic [31:0] next_addr;
    logic        unused_addr_bits;

    assign ARLEN   = 8'd15;
    assign ARSIZE  = 3'b011;
    assign ARBURST = 2'b01;

    assign unused_addr_bits = ^DISPADDR[6:0];

    always_comb begin
        frame_len = LEN_VGA;
        case (resol)
            2'b01:   frame_len = LEN_XGA;
            2'b10:   frame_len = LEN_SXGA;
            default: frame_len = LEN_VGA;
        endcase
    end

    assign last_burst = (burst_idx == (frame_len - 16'd1));
    assign handshake  = ARVALID && ARREADY;
    assign beat_wrap  = RBEAT && (beat_cnt == 4'hF);
    // A restart is owed either by a VSTART seen now or by one held earlier
    // while the address phase was still waiting for ARREADY.
    assign restart    = VSTART || pending;

    // Extended by one bit so obeats + 16 cannot wrap in the compare.
    assign need      = {1'b0, obeats} + 17'd16;
    assign free_ext  = 17'(FIFO_FREE);
    assign credit    = (free_ext >= need) && (obursts < MAX_OUT);
    assign next_addr = {base, 7'd0} + {9'd0, burst_idx, 7'd0};

    // Credit counters: only reset clears them, since data for bursts
    // already accepted keeps arriving across frame restarts.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            obeats   <= 16'd0;
            obursts  <= 4'd0;
            beat_cnt <= 4'd0;
        end else begin
            obeats <= obeats + (handshake ? 16'd16 : 16'd0)
                             - (RBEAT     ? 16'd1  : 16'd0);
            case ({handshake, beat_wrap})
                2'b10:   obursts <= obursts + 4'd1;
                2'b01:   obursts <= obursts - 4'd1;
                default: obursts <= obursts;
            endcase
            if (RBEAT) begin
                beat_cnt <= beat_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state          <= S_IDLE;
            ARVALID        <= 1'b0;
            ARADDR         <= 32'd0;
            FRAME_REQ_DONE <= 1'b0;
            FETCH_LATE     <= 1'b0;
            base           <= 25'd0;
            resol          <= 2'b00;
            burst_idx      <= 16'd0;
            pending        <= 1'b0;
        end else begin
            FRAME_REQ_DONE <= 1'b0;
            FETCH_LATE     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (DISPON) begin
                        state <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (!DISPON) begin
                        state <= S_IDLE;
                    end else if (VSTART) begin
                        base      <= DISPADDR[31:7];
                        resol     <= RESOL;
                        burst_idx <= 16'd0;
                        state     <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (!DISPON) begin
                        state <= S_IDLE;
                    end else if (VSTART) begin
                        // Late frame start with no address in flight:
                        // restart the walk immediately.
                        FETCH_LATE <= 1'b1;
                        base       <= DISPADDR[31:7];
                        resol      <= RESOL;
                        burst_idx  <= 16'd0;
                    end else if (credit) begin
                        ARADDR  <= next_addr;
                        ARVALID <= 1'b1;
                        state   <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    // The new base is latched as soon as VSTART is seen; the
                    // burst on the bus already holds its own registered address.
                    if (VSTART) begin
                        FETCH_LATE <= 1'b1;
                        base       <= DISPADDR[31:7];
                        resol      <= RESOL;
                    end
                    if (handshake) begin
                        ARVALID <= 1'b0;
                        pending <= 1'b0;
                        if (restart) begin
                            burst_idx <= 16'd0;
                            state     <= DISPON ? S_CHECK : S_IDLE;
                        end else begin
                            burst_idx <= burst_idx + 16'd1;
                            if (last_burst) begin
                                FRAME_REQ_DONE <= 1'b1;
                                state          <= DISPON ? S_ARM : S_IDLE;
                            end else begin
                                state <= DISPON ? S_CHECK : S_IDLE;
                            end
                        end
                    end else if (VSTART) begin
                        pending <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
